// File: rtl/configurable_division_pkg.sv
// Shared mode, state and iteration-count definitions for the sequential divider.
package configurable_division_pkg;

  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] CM_SINGLE8  = 2'b00;
  localparam logic [1:0] CM_DUAL8    = 2'b01;
  localparam logic [1:0] CM_SINGLE16 = 2'b10;
  localparam logic [1:0] CM_RSVD     = 2'b11;

  localparam logic [CNT_W-1:0] ITER_8  = CNT_W'(8);
  localparam logic [CNT_W-1:0] ITER_16 = CNT_W'(16);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of restoring iterations an operation in mode cm takes.
  function automatic logic [CNT_W-1:0] iter_count(input logic [1:0] cm);
    return (cm == CM_SINGLE16) ? ITER_16 : ITER_8;
  endfunction

endpackage

// File: rtl/division_step.sv
// One combinational restoring-division iteration on a W-bit lane.
module division_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  // Shift in the next dividend bit, then trial-subtract; the extra top bit is the sign.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, divisor_i};
    q_o     = ~diff[W+1];
    rem_o   = diff[W+1] ? shifted[W:0] : diff[W:0];
  end

endmodule

// File: rtl/configurable_division.sv
// Sequential restoring divider: single 8-bit, dual 8-bit lanes or single 16-bit.
module configurable_division
  import configurable_division_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  input  logic         enable_i,
  input  logic [1:0]   cm_i,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o,
  output logic [1:0]   div_by_zero_o,
  output logic         busy_o,
  output logic         data_valid_o
);

  localparam int unsigned LW = W / 2;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         cm_q, cm_d;
  logic [W-1:0]       dvd_q, dvd_d;
  logic [W-1:0]       dvs_q, dvs_d;
  logic [LW:0]        rem_l_q, rem_l_d;
  logic [LW:0]        rem_h_q, rem_h_d;
  logic [W:0]         rem_w_q, rem_w_d;
  logic [W-1:0]       quo_q, quo_d;
  logic [W-1:0]       rmd_q, rmd_d;
  logic [1:0]         dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;

  logic [LW:0]        rem_l_nx, rem_h_nx;
  logic [W:0]         rem_w_nx;
  logic               q_l, q_h, q_w;
  logic [W-1:0]       dvd_shift;
  logic [W-1:0]       rmd_final;

  division_step #(.W(LW)) u_step_l (
    .rem_i     (rem_l_q),
    .bit_i     (dvd_q[LW-1]),
    .divisor_i (dvs_q[LW-1:0]),
    .rem_o     (rem_l_nx),
    .q_o       (q_l)
  );

  division_step #(.W(LW)) u_step_h (
    .rem_i     (rem_h_q),
    .bit_i     (dvd_q[W-1]),
    .divisor_i (dvs_q[W-1:LW]),
    .rem_o     (rem_h_nx),
    .q_o       (q_h)
  );

  division_step #(.W(W)) u_step_w (
    .rem_i     (rem_w_q),
    .bit_i     (dvd_q[W-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_w_nx),
    .q_o       (q_w)
  );

  // Dividend register doubles as the quotient shift register; lanes never exchange bits.
  always_comb begin
    dvd_shift = {dvd_q[W-2:LW], q_h, dvd_q[LW-2:0], q_l};
    rmd_final = {rem_h_nx[LW-1:0], rem_l_nx[LW-1:0]};
    if (cm_q == CM_SINGLE16) begin
      dvd_shift = {dvd_q[W-2:0], q_w};
      rmd_final = rem_w_nx[W-1:0];
    end else if (cm_q == CM_SINGLE8) begin
      rmd_final = {{LW{1'b0}}, rem_l_nx[LW-1:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cm_d    = cm_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_l_d = rem_l_q;
    rem_h_d = rem_h_q;
    rem_w_d = rem_w_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (enable_i && (cm_i != CM_RSVD)) begin
          state_d = CALC;
          cm_d    = cm_i;
          cnt_d   = iter_count(cm_i);
          dvd_d   = dividend_i;
          dvs_d   = divisor_i;
          if (cm_i == CM_SINGLE8) begin
            dvd_d[W-1:LW] = '0;
            dvs_d[W-1:LW] = '0;
          end
          rem_l_d = '0;
          rem_h_d = '0;
          rem_w_d = '0;
        end
      end
      CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        dvd_d = dvd_shift;
        if (cm_q == CM_SINGLE16) begin
          rem_w_d = rem_w_nx;
        end else begin
          rem_l_d = rem_l_nx;
          rem_h_d = rem_h_nx;
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          rmd_d   = rmd_final;
          quo_d   = dvd_shift;
          dbz_d   = {1'b0, (dvs_q[LW-1:0] == '0)};
          if (cm_q == CM_SINGLE16) begin
            dbz_d = {1'b0, (dvs_q == '0)};
          end else if (cm_q == CM_DUAL8) begin
            dbz_d[1] = (dvs_q[W-1:LW] == '0);
          end else begin
            quo_d[W-1:LW] = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cm_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_l_q <= '0;
      rem_h_q <= '0;
      rem_w_q <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cm_q    <= cm_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_l_q <= rem_l_d;
      rem_h_q <= rem_h_d;
      rem_w_q <= rem_w_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign quotient_o    = quo_q;
  assign remainder_o   = rmd_q;
  assign div_by_zero_o = dbz_q;
  assign busy_o        = busy_q;
  assign data_valid_o  = valid_q;

endmodule

// File: tb/tb_configurable_division.sv
// Directed-vector bench for configurable_division with hand-computed results.
module tb_configurable_division;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] dividend_i;
  logic [15:0] divisor_i;
  logic        enable_i;
  logic [1:0]  cm_i;
  logic [15:0] quotient_o;
  logic [15:0] remainder_o;
  logic [1:0]  div_by_zero_o;
  logic        busy_o;
  logic        data_valid_o;

  int n_total = 0;
  int n_pass  = 0;
  logic [15:0] prev_q;

  configurable_division #(.W(16)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .enable_i      (enable_i),
    .cm_i          (cm_i),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o),
    .busy_o        (busy_o),
    .data_valid_o  (data_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One operation driven by a single-cycle enable; checks latency, strobe width and results.
  task automatic run_op(input string tag, input logic [1:0] cm, input logic [15:0] dvd,
                        input logic [15:0] dvs, input int lat, input logic [15:0] eq,
                        input logic [15:0] er, input logic [1:0] edbz);
    int cyc;
    @(negedge clk_i);
    cm_i = cm; dividend_i = dvd; divisor_i = dvs; enable_i = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b0; cm_i = 2'b11; dividend_i = 16'hFFFF; divisor_i = 16'hFFFF;
    check({tag, "_busy_calc"}, 32'(busy_o), 32'd1);
    check({tag, "_hold_q"}, 32'(quotient_o), 32'(prev_q));
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk_i); #1;
      cyc++;
      if (data_valid_o) break;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_quot"}, 32'(quotient_o), 32'(eq));
    check({tag, "_rem"}, 32'(remainder_o), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero_o), 32'(edbz));
    check({tag, "_busy_done"}, 32'(busy_o), 32'd1);
    @(posedge clk_i); #1;
    check({tag, "_valid_1cyc"}, 32'(data_valid_o), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy_o), 32'd0);
    prev_q = eq;
  endtask

  initial begin
    int cyc;
    int n_pulse;
    int pulse_at [4];
    int busy_seen;
    int valid_seen;

    reset_i = 1'b1; enable_i = 1'b0; cm_i = 2'b00; dividend_i = '0; divisor_i = '0;
    prev_q = 16'h0000;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_quot", 32'(quotient_o), 32'd0);
    check("rst_rem", 32'(remainder_o), 32'd0);
    check("rst_flags", 32'({div_by_zero_o, busy_o, data_valid_o}), 32'd0);
    @(negedge clk_i); reset_i = 1'b0;

    run_op("m10",     2'b10, 16'd40000, 16'd123, 16, 16'd325,  16'd25,   2'b00);
    run_op("m01",     2'b01, 16'hC863,  16'h070A, 8, 16'h1C09, 16'h0409, 2'b00);
    run_op("m00",     2'b00, 16'hABFF,  16'h5510, 8, 16'h000F, 16'h000F, 2'b00);
    run_op("m01_dz",  2'b01, 16'h3C05,  16'h0002, 8, 16'hFF02, 16'h3C01, 2'b10);
    run_op("m10_dz",  2'b10, 16'h1234,  16'h0000, 16, 16'hFFFF, 16'h1234, 2'b01);
    run_op("m00_dz",  2'b00, 16'h7709,  16'hAA00, 8, 16'h00FF, 16'h0009, 2'b01);

    // Reset in the middle of a 16-bit operation.
    @(negedge clk_i);
    cm_i = 2'b10; dividend_i = 16'd50000; divisor_i = 16'd7; enable_i = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i); reset_i = 1'b1;
    @(posedge clk_i); #1;
    check("midrst_quot", 32'(quotient_o), 32'd0);
    check("midrst_rem", 32'(remainder_o), 32'd0);
    check("midrst_flags", 32'({div_by_zero_o, busy_o, data_valid_o}), 32'd0);
    @(negedge clk_i); reset_i = 1'b0;
    valid_seen = 0;
    repeat (20) begin
      @(posedge clk_i); #1;
      if (data_valid_o) valid_seen++;
    end
    check("midrst_no_valid", 32'(valid_seen), 32'd0);
    prev_q = 16'h0000;
    run_op("post_rst", 2'b10, 16'd50000, 16'd7, 16, 16'd7142, 16'd6, 2'b00);

    // Enable held high in mode 10: one result every 18 cycles.
    @(negedge clk_i);
    cm_i = 2'b10; dividend_i = 16'd40000; divisor_i = 16'd123; enable_i = 1'b1;
    n_pulse = 0;
    for (int i = 0; i < 4; i++) pulse_at[i] = 0;
    for (cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk_i); #1;
      if (data_valid_o) begin
        if (n_pulse < 4) pulse_at[n_pulse] = cyc;
        n_pulse++;
      end
    end
    check("held_pulses", 32'(n_pulse), 32'd4);
    check("held_first", 32'(pulse_at[0]), 32'd17);
    check("held_gap1", 32'(pulse_at[1] - pulse_at[0]), 32'd18);
    check("held_gap2", 32'(pulse_at[2] - pulse_at[1]), 32'd18);
    check("held_quot", 32'(quotient_o), 32'd325);
    @(negedge clk_i); enable_i = 1'b0;
    repeat (25) @(posedge clk_i);
    #1;
    check("held_drain_idle", 32'(busy_o), 32'd0);

    // Reserved mode never starts.
    @(negedge clk_i);
    cm_i = 2'b11; enable_i = 1'b1;
    busy_seen = 0; valid_seen = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (busy_o) busy_seen++;
      if (data_valid_o) valid_seen++;
    end
    check("rsvd_busy", 32'(busy_seen), 32'd0);
    check("rsvd_valid", 32'(valid_seen), 32'd0);
    @(negedge clk_i); enable_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
